// File: rtl/key_press_classifier.sv
// key_press_classifier
// Turns the debouncer's press/release edge pulses into short-press, long-press,
// double-click and auto-repeat event pulses. One shared saturating counter times
// the hold, the double-click window and the repeat period.
module key_press_classifier #(
    parameter int LONG_CYC   = 8,
    parameter int DOUBLE_CYC = 5,
    parameter int REPEAT_CYC = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,    // asynchronous, active-high despite the name
    input  logic i_press,
    input  logic i_release,
    output logic o_short,
    output logic o_long,
    output logic o_repeat,
    output logic o_double,
    output logic o_busy
);

    localparam int MAX_LD  = (LONG_CYC > DOUBLE_CYC) ? LONG_CYC : DOUBLE_CYC;
    localparam int MAX_CYC = (MAX_LD > REPEAT_CYC) ? MAX_LD : REPEAT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DOUBLE_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HELD1 = 3'd1,
        S_WAIT2 = 3'd2,
        S_HELD2 = 3'd3,
        S_LONG  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;

    logic r_short;
    logic r_long;
    logic r_repeat;
    logic r_double;

    logic w_short_next;
    logic w_long_next;
    logic w_repeat_next;
    logic w_double_next;

    // A simultaneous press and release is contradictory; drop both.
    logic w_press;
    logic w_release;
    assign w_press   = i_press & ~i_release;
    assign w_release = i_release & ~i_press;

    // State register with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode. The IDLE cycle in which o_short is pulsing does not
    // accept a press: a press coinciding with the short timeout is dropped.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_press && !r_short) begin
                    w_state_next = S_HELD1;
                end
            end
            S_HELD1: begin
                if (w_release) begin
                    w_state_next = S_WAIT2;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_next = S_LONG;
                end
            end
            S_WAIT2: begin
                if (w_press) begin
                    w_state_next = S_HELD2;
                end else if (r_cnt == DBL_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            S_HELD2: begin
                if (w_release) begin
                    w_state_next = S_IDLE;
                end
            end
            S_LONG: begin
                if (w_release) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Event decode; release/press edges always win over a same-cycle timeout.
    always_comb begin
        w_short_next  = 1'b0;
        w_long_next   = 1'b0;
        w_repeat_next = 1'b0;
        w_double_next = 1'b0;
        case (r_state)
            S_HELD1: w_long_next   = !w_release && (r_cnt == LONG_LAST);
            S_WAIT2: w_short_next  = !w_press && (r_cnt == DBL_LAST);
            S_HELD2: w_double_next = w_release;
            S_LONG:  w_repeat_next = !w_release && (r_cnt == REP_LAST);
            default: ;
        endcase
    end

    // Shared counter: cleared on every state entry and on each repeat tick,
    // otherwise counts (saturating) in the timed states.
    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            r_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state == S_LONG && r_cnt == REP_LAST) begin
            r_cnt <= '0;
        end else if ((r_state == S_HELD1 || r_state == S_WAIT2 || r_state == S_LONG)
                     && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered single-cycle event pulses.
    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_double <= 1'b0;
        end else begin
            r_short  <= w_short_next;
            r_long   <= w_long_next;
            r_repeat <= w_repeat_next;
            r_double <= w_double_next;
        end
    end

    assign o_short  = r_short;
    assign o_long   = r_long;
    assign o_repeat = r_repeat;
    assign o_double = r_double;
    assign o_busy   = (r_state != S_IDLE);

endmodule
